line_delay_buffer: RTL and testbench

Ping-pong line buffer directly downstream of the parallel-video capture stage. Stores each incoming active line of 12-bit pixels and replays it one line later, aligned to the next line's DE window, on the 4-bit-per-channel VGA outputs. Syncs and DE are forwarded with a fixed pipeline delay. It is the decoupling stage needed before any line-based filtering.

---
 rtl/vid_pkg.sv | 33 +++
 rtl/line_bank_ram.sv | 42 ++++
 rtl/line_delay_buffer.sv | 190 +++++++++++++++++++
 tb/tb_line_delay_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared video-pipeline defaults, pixel field slices, line-buffer state enum.
// Latency: none (constants, types and one combinational helper).
// Backpressure: none.
//
// Pixel layout is {blue[11:8], red[7:4], green[3:0]}.
package vid_pkg;

   localparam int H_ACTIVE_DFLT = 800;
   localparam int ADDR_W_DFLT   = 10;
   localparam int PIX_W_DFLT    = 12;

   localparam int BLUE_HI  = 11;
   localparam int BLUE_LO  = 8;
   localparam int RED_HI   = 7;
   localparam int RED_LO   = 4;
   localparam int GREEN_HI = 3;
   localparam int GREEN_LO = 0;

   typedef enum logic [1:0] {
      WAIT_FRAME = 2'd0,
      FIRST_LINE = 2'd1,
      STREAM     = 2'd2
   } lb_state_t;

   // Mean of three 4-bit channels, truncated. Max sum is 45, so 6 bits suffice.
   function automatic logic [3:0] gray4(input logic [3:0] r, input logic [3:0] g,
                                        input logic [3:0] b);
      logic [5:0] sum;
      sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
      return 4'(sum / 6'd3);
   endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Two-bank line store: one write port, one synchronous read port.
// Latency: read data valid 1 cycle after rd_addr is presented.
// Backpressure: none; writes and reads are accepted every cycle.
//
// Ports: clk; wr_vld/wr_addr/wr_dat write port; rd_addr/rd_dat read port.
// Address MSB selects the bank, low ADDR_W bits are the pixel index.
module line_bank_ram
   #(
   parameter int H_ACTIVE = 800,
   parameter int ADDR_W   = 10,
   parameter int PIX_W    = 12
   ) (
   input  logic              clk,
   input  logic              wr_vld,
   input  logic [ADDR_W:0]   wr_addr,
   input  logic [PIX_W-1:0]  wr_dat,
   input  logic [ADDR_W:0]   rd_addr,
   output logic [PIX_W-1:0]  rd_dat
   );

   localparam int              AW       = ADDR_W + 1;
   localparam int              DEPTH    = 2 * H_ACTIVE;
   localparam logic [ADDR_W:0] BANK_OFS = AW'(H_ACTIVE);

   logic [PIX_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]  wr_idx, rd_idx;
   logic             wr_in_range, rd_in_range;

   // Bank 1 is packed directly above bank 0, so the array holds exactly two
   // lines even when H_ACTIVE is not a power of two.
   assign wr_idx = (wr_addr[ADDR_W] ? BANK_OFS : '0) + {1'b0, wr_addr[ADDR_W-1:0]};
   assign rd_idx = (rd_addr[ADDR_W] ? BANK_OFS : '0) + {1'b0, rd_addr[ADDR_W-1:0]};
   assign wr_in_range = {1'b0, wr_addr[ADDR_W-1:0]} < BANK_OFS;
   assign rd_in_range = {1'b0, rd_addr[ADDR_W-1:0]} < BANK_OFS;

   always_ff @(posedge clk) begin
      if (wr_vld && wr_in_range) mem[wr_idx] <= wr_dat;
      // Out-of-range reads (overflowed line) hold; the caller blanks them.
      if (rd_in_range) rd_dat <= mem[rd_idx];
   end

endmodule

// File: rtl/line_delay_buffer.sv
// Ping-pong line buffer: replays each active line one line later on VGA nibbles.
// Latency: 2 cycles from de/hsync/vsync in to out (RAM read, output register).
// Backpressure: none; free-running video stream, excess pixels past H_ACTIVE dropped.
//
// Ports: clk, rst_n (async active-low); de_in/hsync_in/vsync_in/pix_in capture side;
// vga_red/green/blue, hsync_out/vsync_out/de_out replay side; line_cnt (lines done
// this frame, saturating), ovf (sticky, a line exceeded H_ACTIVE).
// Optional: define LINE_DELAY_GRAY_EN to output the channel mean on all colours.
module line_delay_buffer
   import vid_pkg::*;
   #(
   parameter int H_ACTIVE = H_ACTIVE_DFLT,
   parameter int ADDR_W   = ADDR_W_DFLT,
   parameter int PIX_W    = PIX_W_DFLT
   ) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              de_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [PIX_W-1:0]  pix_in,
   output logic [3:0]        vga_red,
   output logic [3:0]        vga_green,
   output logic [3:0]        vga_blue,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              de_out,
   output logic [9:0]        line_cnt,
   output logic              ovf
   );

   // Counters carry one extra bit so they can hold H_ACTIVE itself.
   localparam int              XW    = ADDR_W + 1;
   localparam logic [ADDR_W:0] X_LIM = XW'(H_ACTIVE);
   localparam logic [ADDR_W:0] X_ONE = XW'(1);

   lb_state_t        state, state_nxt;
   logic             wr_active, rd_active;
   logic             de_prev, vs_prev, de_fall, vs_rise;
   logic             wr_bank, rd_bank;
   logic [ADDR_W:0]  wr_x, rd_x;
   logic [ADDR_W:0]  len [2];
   logic [1:0]       valid;
   logic             at_limit, ram_wr_vld;
   logic [PIX_W-1:0] rd_dat;
   logic             de_d1, hs_d1, vs_d1, show_d1;
   logic [3:0]       red_nxt, green_nxt, blue_nxt;

   assign de_fall  = de_prev & ~de_in;
   assign vs_rise  = ~vs_prev & vsync_in;
   assign rd_bank  = ~wr_bank;
   assign rd_x     = wr_x;            // read index runs in lockstep with write index
   assign at_limit = (wr_x == X_LIM);
   assign ram_wr_vld = wr_active & vsync_in & de_in & ~at_limit;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_FRAME;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!vsync_in) begin
         state_nxt = WAIT_FRAME;
      end else begin
         case (state)
            WAIT_FRAME: if (vs_rise) state_nxt = FIRST_LINE;
            FIRST_LINE: if (de_fall) state_nxt = STREAM;
            STREAM:     state_nxt = STREAM;
            default:    state_nxt = WAIT_FRAME;
         endcase
      end
   end

   always_comb begin
      wr_active = 1'b0;
      rd_active = 1'b0;
      case (state)
         FIRST_LINE: wr_active = 1'b1;
         STREAM: begin
            wr_active = 1'b1;
            rd_active = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------- write side / bank bookkeeping ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_prev  <= 1'b0;
         vs_prev  <= 1'b1;
         wr_bank  <= 1'b0;
         wr_x     <= '0;
         len[0]   <= '0;
         len[1]   <= '0;
         valid    <= '0;
         line_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         de_prev <= de_in;
         vs_prev <= vsync_in;
         // Vertical blanking beats a coincident DE fall: the line is dropped.
         if (!vsync_in) begin
            valid    <= '0;
            wr_x     <= '0;
            wr_bank  <= 1'b0;
            line_cnt <= '0;
         end else if (wr_active) begin
            if (de_fall) begin
               len[wr_bank]   <= wr_x;
               valid[wr_bank] <= 1'b1;
               wr_bank        <= ~wr_bank;
               wr_x           <= '0;
               if (line_cnt != 10'h3FF) line_cnt <= line_cnt + 10'd1;
            end else if (de_in) begin
               if (at_limit) ovf  <= 1'b1;
               else          wr_x <= wr_x + X_ONE;
            end
         end
      end
   end

   line_bank_ram #(
      .H_ACTIVE (H_ACTIVE),
      .ADDR_W   (ADDR_W),
      .PIX_W    (PIX_W)
   ) u_ram (
      .clk      (clk),
      .wr_vld   (ram_wr_vld),
      .wr_addr  ({wr_bank, wr_x[ADDR_W-1:0]}),
      .wr_dat   (pix_in),
      .rd_addr  ({rd_bank, rd_x[ADDR_W-1:0]}),
      .rd_dat   (rd_dat)
   );

   // ---------------- stage 1: aligned with RAM read ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_d1   <= 1'b0;
         hs_d1   <= 1'b1;
         vs_d1   <= 1'b1;
         show_d1 <= 1'b0;
      end else begin
         de_d1   <= de_in;
         hs_d1   <= hsync_in;
         vs_d1   <= vsync_in;
         show_d1 <= rd_active & vsync_in & de_in & valid[rd_bank] & (rd_x < len[rd_bank]);
      end
   end

   always_comb begin
      red_nxt   = '0;
      green_nxt = '0;
      blue_nxt  = '0;
      if (de_d1 && show_d1) begin
`ifdef LINE_DELAY_GRAY_EN
         red_nxt   = gray4(rd_dat[RED_HI:RED_LO], rd_dat[GREEN_HI:GREEN_LO],
                           rd_dat[BLUE_HI:BLUE_LO]);
         green_nxt = red_nxt;
         blue_nxt  = red_nxt;
`else
         red_nxt   = rd_dat[RED_HI:RED_LO];
         green_nxt = rd_dat[GREEN_HI:GREEN_LO];
         blue_nxt  = rd_dat[BLUE_HI:BLUE_LO];
`endif
      end
   end

   // ---------------- stage 2: output register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_red   <= '0;
         vga_green <= '0;
         vga_blue  <= '0;
         de_out    <= 1'b0;
         hsync_out <= 1'b1;
         vsync_out <= 1'b1;
      end else begin
         vga_red   <= red_nxt;
         vga_green <= green_nxt;
         vga_blue  <= blue_nxt;
         de_out    <= de_d1;
         hsync_out <= hs_d1;
         vsync_out <= vs_d1;
      end
   end

endmodule

// File: tb/tb_line_delay_buffer.sv
// Randomized bench for line_delay_buffer against a line-level reference model.
// Latency: model expectations are queued and compared 2 cycles later.
// Backpressure: none.
module tb_line_delay_buffer;

   localparam int H = 800;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        de_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
   logic [11:0] pix_in = '0;
   logic [3:0]  vga_red, vga_green, vga_blue;
   logic        hsync_out, vsync_out, de_out, ovf;
   logic [9:0]  line_cnt;

   always #5 clk = ~clk;

   line_delay_buffer #(.H_ACTIVE(H), .ADDR_W(10), .PIX_W(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .de_in     (de_in),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .pix_in    (pix_in),
      .vga_red   (vga_red),
      .vga_green (vga_green),
      .vga_blue  (vga_blue),
      .hsync_out (hsync_out),
      .vsync_out (vsync_out),
      .de_out    (de_out),
      .line_cnt  (line_cnt),
      .ovf       (ovf)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // prev_q is the last completed line of this frame (empty = nothing to show),
   // cur_q the line being captured; the replay of pixel x is prev_q[x] if present.
   logic [11:0] prev_q[$];
   logic [11:0] cur_q[$];
   logic [14:0] exp_q[$];       // {de, hs, vs, blue, red, green} per input cycle
   bit          m_wait, m_de_prev, m_vs_prev, m_ovf;
   int          m_lines;

   function automatic logic [11:0] colour_of(input logic [11:0] p);
`ifdef LINE_DELAY_GRAY_EN
      int         s;
      logic [3:0] g;
      s = int'(p[11:8]) + int'(p[7:4]) + int'(p[3:0]);
      g = 4'(s / 3);
      return {g, g, g};
`else
      return p;
`endif
   endfunction

   task automatic model_step(input logic de, input logic hs, input logic vs,
                             input logic [11:0] pix);
      logic [11:0] col;
      int          x;
      col = '0;
      if (!vs) begin
         m_wait  = 1'b1;
         prev_q.delete();
         cur_q.delete();
         m_lines = 0;
      end else if (m_wait) begin
         if (!m_vs_prev) m_wait = 1'b0;
      end else if (de) begin
         x = cur_q.size();
         if (x < prev_q.size()) col = colour_of(prev_q[x]);
         if (x < H) cur_q.push_back(pix);
         else       m_ovf = 1'b1;
      end else if (m_de_prev) begin
         prev_q = cur_q;
         cur_q.delete();
         if (m_lines < 1023) m_lines++;
      end
      m_de_prev = de;
      m_vs_prev = vs;
      exp_q.push_back({de, hs, vs, col});
   endtask

   // Called right after rst_n is released: the first queued entry is the
   // reset output, the second the inputs still being held on the pins.
   task automatic model_after_release();
      exp_q.delete();
      prev_q.delete();
      cur_q.delete();
      m_wait = 1'b1; m_de_prev = 1'b0; m_vs_prev = 1'b1; m_ovf = 1'b0; m_lines = 0;
      exp_q.push_back({1'b0, 1'b1, 1'b1, 12'h000});
      model_step(de_in, hsync_in, vsync_in, pix_in);
   endtask

   // ---------------- one clock cycle of stimulus + checks ----------------
   task automatic cyc(input logic de, input logic hs, input logic vs, input logic [11:0] pix);
      int          lc_e;
      bit          ovf_e;
      logic [14:0] e;
      @(posedge clk);
      #1;
      lc_e  = m_lines;
      ovf_e = m_ovf;
      de_in = de; hsync_in = hs; vsync_in = vs; pix_in = pix;
      model_step(de, hs, vs, pix);
      @(negedge clk);
      chk("line_cnt", line_cnt, lc_e);
      chk("ovf", ovf, ovf_e);
      if (exp_q.size() > 2) begin
         e = exp_q.pop_front();
         chk("video", {de_out, hsync_out, vsync_out, vga_blue, vga_red, vga_green}, e);
      end
   endtask

   task automatic start_frame();
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 12'($urandom));
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 12'($urandom));
   endtask

   // mode 0: ramp, 1: random, 2: grey-scale corner values then random.
   // kill: vsync drops in the very cycle DE falls.
   task automatic drive_line(input int n, input int mode, input bit kill);
      logic [11:0] p;
      int          blank;
      blank = $urandom_range(1, 8);
      for (int x = 0; x < n; x++) begin
         case (mode)
            0:       p = 12'(x);
            2:       p = (x == 0) ? 12'hF30 : (x == 1) ? 12'hFFF :
                         (x == 2) ? 12'h000 : 12'($urandom);
            default: p = 12'($urandom);
         endcase
         cyc(1'b1, 1'b1, 1'b1, p);
      end
      for (int i = 0; i < blank; i++) cyc(1'b0, (i != 0), !kill, 12'($urandom));
   endtask

   task automatic chk_reset_values(input string pfx);
      chk({pfx, "_vga"}, {vga_blue, vga_red, vga_green}, 0);
      chk({pfx, "_de_out"}, de_out, 0);
      chk({pfx, "_hsync_out"}, hsync_out, 1);
      chk({pfx, "_vsync_out"}, vsync_out, 1);
      chk({pfx, "_line_cnt"}, line_cnt, 0);
      chk({pfx, "_ovf"}, ovf, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_values("rst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_after_release();

      // Two ramp lines: first replay black, second replays the ramp.
      start_frame();
      drive_line(800, 0, 0);
      drive_line(800, 0, 0);

      // Short line then full lines: tail of the short replay is black.
      start_frame();
      drive_line(400, 1, 0);
      drive_line(800, 1, 0);
      drive_line(800, 1, 0);

      // Overflowing line.
      start_frame();
      drive_line(805, 1, 0);
      drive_line(800, 1, 0);
      drive_line(300, 1, 0);

      // Five lines, vsync falls together with the fifth DE fall.
      start_frame();
      chk("ovf_sticky", ovf, 1);
      for (int l = 0; l < 4; l++) drive_line($urandom_range(50, 800), 1, 0);
      drive_line(600, 1, 1);

      // Grey-scale corner values replayed on the next line.
      start_frame();
      drive_line(16, 2, 0);
      drive_line(100, 1, 0);
      drive_line(100, 1, 0);

      // Reset pulse in the middle of an active line.
      for (int i = 0; i < 60; i++) cyc(1'b1, 1'b1, 1'b1, 12'($urandom));
      #2 rst_n = 1'b0;
      #1 chk_reset_values("midrst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_after_release();
      for (int i = 0; i < 60; i++) cyc(1'b1, 1'b1, 1'b1, 12'($urandom));
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 12'($urandom));
      drive_line(200, 1, 0);
      start_frame();
      for (int l = 0; l < 3; l++) drive_line(200, 1, 0);

      // Random lengths, some overflowing.
      start_frame();
      for (int l = 0; l < 4; l++) drive_line($urandom_range(1, 820), 1, 0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 12'h000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
